// File: rtl/audio_decimator.sv
// Decimating boxcar filter: each output sample is the mean of 2**LOG2_RATIO input samples.
// Define AUDIO_DECIMATOR_ROUND_EN to round half up instead of truncating toward -inf.
module audio_decimator #(
    parameter int SAMPLE_SIZE = 16,
    parameter int LOG2_RATIO  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          s_tvalid,
    input  logic signed [SAMPLE_SIZE-1:0] s_tdata,
    output logic                          s_tready,
    output logic                          m_tvalid,
    output logic signed [SAMPLE_SIZE-1:0] m_tdata,
    input  logic                          m_tready
);

    localparam int ACC_W = SAMPLE_SIZE + LOG2_RATIO;

    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      sample_ext;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      total;
    logic        [LOG2_RATIO-1:0] phase;
    logic                         in_fire;
    logic                         out_fire;
    logic                         last_phase;

    // A new sample may enter whenever the output register is empty or draining this cycle.
    assign s_tready   = !m_tvalid || m_tready;
    assign in_fire    = s_tvalid && s_tready;
    assign out_fire   = m_tvalid && m_tready;
    assign last_phase = &phase;

    assign sample_ext = {{LOG2_RATIO{s_tdata[SAMPLE_SIZE-1]}}, s_tdata};
    assign sum        = acc + sample_ext;

`ifdef AUDIO_DECIMATOR_ROUND_EN
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (LOG2_RATIO - 1);
    assign total = sum + ROUND_BIAS;
`else
    assign total = sum;
`endif

    // The arithmetic shift by LOG2_RATIO is just the top SAMPLE_SIZE bits of the sum.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc      <= '0;
            phase    <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else begin
            if (out_fire) begin
                m_tvalid <= 1'b0;
            end
            if (in_fire) begin
                if (last_phase) begin
                    m_tdata  <= total[ACC_W-1:LOG2_RATIO];
                    m_tvalid <= 1'b1;
                    acc      <= '0;
                    phase    <= '0;
                end else begin
                    acc      <= sum;
                    phase    <= phase + LOG2_RATIO'(1);
                end
            end
        end
    end

endmodule

// File: doc/audio_decimator.md
Name: audio_decimator

Overview:
- Decimating boxcar (averaging) filter placed directly downstream of the audio oscillator's AXI-Stream output.
- Each output sample is the mean of 2**LOG2_RATIO consecutive input samples.
- Provides the "filter and decimate" step after the oscillator runs at an oversampled rate, which cuts alias energy before the sample stream goes to the codec path.
- AXI-Stream-style valid/ready handshake on both sides, with full backpressure and no sample loss.

Parameters:
- SAMPLE_SIZE, 16: width of input and output samples; two's complement signed.
- LOG2_RATIO, 2: log2 of the decimation ratio; legal range 1..8, so the ratio is 2..256.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- s_tvalid  input  1  input sample valid (from the oscillator's tvalid).
- s_tdata  input  SAMPLE_SIZE  input sample, signed.
- s_tready  output  1  block can accept an input sample.
- m_tvalid  output  1  output sample valid.
- m_tdata  output  SAMPLE_SIZE  averaged output sample, signed.
- m_tready  input  1  downstream accepts the output sample.

Behaviour:
- Reset: synchronous; takes priority over all other updates in the same cycle.
  - Values after reset: m_tvalid=0, m_tdata=0, accumulator=0, phase counter=0.
- Reset mid-accumulation: all partial sums are discarded and no output is produced.
- Definitions:
  - Input transaction: s_tvalid & s_tready.
  - Output transaction: m_tvalid & m_tready.
- s_tready = !m_tvalid | m_tready. This is combinational and depends only on registered m_tvalid and on m_tready. s_tready is high during reset.
- Accumulator:
  - Signed, SAMPLE_SIZE+LOG2_RATIO bits.
  - Each input sample is sign-extended before it is added.
  - It cannot overflow by construction.
- Phase counter: LOG2_RATIO bits; counts input transactions 0..RATIO-1.
- On an input transaction with phase < RATIO-1: acc <= acc + s_tdata; phase <= phase+1.
- On an input transaction with phase == RATIO-1 (completion):
  - sum = acc + s_tdata.
  - m_tdata <= low SAMPLE_SIZE bits of (sum >>> LOG2_RATIO), using an arithmetic shift.
  - m_tvalid <= 1; acc <= 0; phase <= 0.
- Latency: m_tvalid rises on the clock edge that accepts the RATIO-th sample, i.e. one cycle after that sample is presented.
- Output transaction with no completion in the same cycle: m_tvalid <= 0.
- Output transaction and completion in the same cycle:
  - m_tvalid stays 1 and m_tdata is loaded with the new result.
  - This gives full throughput of one output every RATIO input cycles, or every cycle at the completion boundary.
- Backpressure (m_tvalid=1, m_tready=0):
  - m_tdata is held stable.
  - s_tready=0, so the accumulator and phase are frozen.
  - No input sample is dropped or duplicated.
- s_tvalid=0: state holds; the phase counter does not advance.
- Rounding without the optional feature is truncation toward negative infinity (floor).
- No saturation logic is needed: the mean of in-range values is always in range.

Optional Feature:
- Macro: AUDIO_DECIMATOR_ROUND_EN.
- Defined: at completion, 2**(LOG2_RATIO-1) is added to sum before the arithmetic shift. This rounds half toward positive infinity. The added term cannot overflow the accumulator width.
- Undefined: plain floor truncation as described above. No extra adder is present.

Test Plan:
- LOG2_RATIO=2, s_tvalid and m_tready held high, inputs 4, 8, 12, 16 -> exactly one output, m_tdata=10, one cycle after the 4th sample is accepted.
- Inputs -1, -1, -1, -2 -> m_tdata=0xFFFE (-2) without ROUND_EN; 0xFFFF (-1) with AUDIO_DECIMATOR_ROUND_EN.
- Extremes: four samples of 0x7FFF -> 0x7FFF; four of 0x8000 -> 0x8000; alternating 0x7FFF/0x8000 -> 0xFFFF without rounding.
- Backpressure:
  - Stimulus: feed a continuous ramp 0..15 while holding m_tready=0 for 10 cycles after the first completion.
  - Required: m_tdata held at 1 and s_tready=0 throughout the hold.
  - After release, outputs are 1, 5, 9, 13 in order, with no loss.
- Reset mid-operation: accept 7, 7, then pulse reset_n=0 for one cycle, then feed 1, 1, 1, 1 -> single output 1; m_tvalid=0 immediately after reset.
- Simultaneous accept and complete: m_tready=1 continuously and s_tvalid=1 every cycle -> m_tvalid asserted exactly one cycle in every four, with no stall (s_tready never low).
